fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one 8-entry, 32-bit FIFO write port among N_REQ requesters.
- Supports locked bursts with a beat limit, and is FIFO-aware: it never issues a write the FIFO would drop, i.e. when FULL or when a read is issued that cycle (the FIFO services RD over WR).
- Sits between the requester clients and the FIFO's WR/dataIn pins. The FIFO's EN is driven elsewhere.

Parameters:
- N_REQ, 4: number of requesters, 2..8.
- DATA_W, 32: data width; must match the FIFO.
- MAX_BURST, 4: maximum beats per grant before forced release, 1..8.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-high reset; takes priority over EN.
- EN  in  1  block enable; when 0, no transfers occur and all state holds.
- REQ  in  N_REQ  per-requester valid; REQ[i]=1 means DATA slice i is valid.
- LAST  in  N_REQ  per-requester last-beat-of-burst flag; qualified by REQ.
- DATA  in  N_REQ*DATA_W  requester data; slice i is bits [i*DATA_W +: DATA_W].
- GNT  out  N_REQ  one-hot-or-zero ready; combinational.
- FIFO_FULL  in  1  the FIFO's FULL flag.
- FIFO_RD  in  1  the RD currently driven to the FIFO.
- FIFO_WR  out  1  to the FIFO's WR; combinational.
- FIFO_DATA  out  DATA_W  to the FIFO's dataIn; combinational mux.
- OWNER  out  3  index of the locked requester; valid when BUSY=1.
- BUSY  out  1  1 while in state BURST.

Behaviour:
- writable = EN & ~Rst & ~FIFO_FULL & ~FIFO_RD.
- Transfer on requester i = REQ[i] & GNT[i], sampled at the rising edge.
- Zero latency: FIFO_WR = OR of all transfers. FIFO_DATA = DATA slice of the granted requester, or 0 when no grant. The FIFO captures the word at the same edge.
- GNT is all-zero whenever writable = 0. No pointer or beat change on a stalled cycle.
- Registers:
  - state in {IDLE, BURST}
  - rr_ptr (last served index)
  - owner
  - beat (3 bits)
- Reset values:
  - state=IDLE, rr_ptr=N_REQ-1, owner=0, beat=0.
  - OWNER=0, BUSY=0; GNT=0 and FIFO_WR=0 while Rst=1.
- IDLE:
  - Winner w = first i with REQ[i]=1, searching rr_ptr+1, rr_ptr+2, ... modulo N_REQ. GNT[w]=writable.
  - On transfer with LAST[w]=1 or MAX_BURST=1: stay IDLE, rr_ptr<=w.
  - On any other transfer: go to BURST, owner<=w, beat<=1.
- BURST:
  - GNT[owner] = writable & REQ[owner]. All other GNT bits are 0.
  - On transfer with LAST[owner]=1 or beat+1=MAX_BURST: go to IDLE, rr_ptr<=owner, beat<=0.
  - On any other transfer: beat<=beat+1.
  - REQ[owner]=0 in any cycle with EN=1: abandon the burst. Go to IDLE, rr_ptr<=owner, beat<=0, no transfer that cycle.
  - FIFO_FULL or FIFO_RD asserted with REQ[owner] held: stay in BURST and wait. Stall cycles do not count as beats.
- A single requester with REQ held permanently is served every writable cycle, but releases after MAX_BURST beats so others can win the next arbitration.
- LAST is ignored when REQ=0.
- EN=0: GNT=0, FIFO_WR=0, all registers hold, including mid-burst. Burst abandon is not evaluated while EN=0.
- Rst mid-burst: next cycle is IDLE with reset values. The partial burst is not resumed.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds output STAT_XFER (N_REQ*16): per-requester saturating transfer counters. Slice i increments on each transfer of requester i and holds at 16'hFFFF.
  - Adds output STAT_STALL (16): saturating count of cycles with EN=1, |REQ=1 and writable=0.
  - All counters clear to 0 on Rst.
- Undefined: neither port nor its counters exist. Arbitration behaviour is identical in both builds.

Test Plan:
- Rst=1 for 2 cycles, then EN=1, REQ=4'b1111, LAST=4'b1111, FIFO idle -> GNT order 0,1,2,3,0; FIFO_WR=1 on all 5 cycles; FIFO_DATA equals the granted slice each cycle.
- REQ[2] held for 6 beats, LAST=0, MAX_BURST=4, REQ[0]=1 -> requester 2 gets 4 consecutive grants (BUSY=1, OWNER=2), then requester 0 is granted, then requester 2 resumes.
- FIFO_FULL=1 for 3 cycles mid-burst (beat=2) -> GNT=0, FIFO_WR=0 for those 3 cycles; after release, exactly 2 more beats complete the burst.
- FIFO_RD=1 with REQ[1]=1 and FIFO not full -> GNT=0 and FIFO_WR=0 that cycle; the transfer happens on the first cycle with FIFO_RD=0, and no data is lost.
- Owner drops REQ after beat 1 of 4, and EN=0 for 2 cycles in a later burst -> abandon returns to IDLE with rr_ptr=owner; during EN=0, state, OWNER and beat are unchanged and FIFO_WR=0.
- ARB_STATS_EN build: 10 transfers from requester 3 and 5 stall cycles -> STAT_XFER slice 3 = 10 and STAT_STALL = 5; Rst clears both to 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter in front of a single FIFO write port.
// Requesters may hold the port for locked bursts of up to MAX_BURST beats.
// Writes are only granted when the FIFO will accept them: not FULL, no RD this cycle.
// Optional build macro ARB_STATS_EN adds saturating per-requester transfer counters
// (STAT_XFER) and a stall-cycle counter (STAT_STALL).
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    EN,
    input  logic [N_REQ-1:0]        REQ,
    input  logic [N_REQ-1:0]        LAST,
    input  logic [N_REQ*DATA_W-1:0] DATA,
    output logic [N_REQ-1:0]        GNT,
    input  logic                    FIFO_FULL,
    input  logic                    FIFO_RD,
    output logic                    FIFO_WR,
    output logic [DATA_W-1:0]       FIFO_DATA,
    output logic [2:0]              OWNER,
`ifdef ARB_STATS_EN
    output logic [N_REQ*16-1:0]     STAT_XFER,
    output logic [15:0]             STAT_STALL,
`endif
    output logic                    BUSY
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    logic       state_q, state_d;
    logic [2:0] rr_q, rr_d;
    logic [2:0] owner_q, owner_d;
    logic [2:0] beat_q, beat_d;

    logic       writable;
    logic [7:0] req_pad;
    logic [7:0] last_pad;
    logic       win_found;
    logic [2:0] win_idx;
    logic [3:0] cand;
    logic       grant_any;
    logic [2:0] sel_idx;
    logic       burst_end;

    // FIFO drops WR when FULL or when RD is serviced the same cycle.
    assign writable = EN & ~Rst & ~FIFO_FULL & ~FIFO_RD;
    // Pad to 8 so a 3-bit index is always in range.
    assign req_pad  = 8'(REQ);
    assign last_pad = 8'(LAST);

    // Round-robin search starting just after the last served requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            cand = {1'b0, rr_q} + 4'(k);
            if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
            if (!win_found && req_pad[cand[2:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[2:0];
            end
        end
    end

    // Grant decode and zero-latency data mux towards the FIFO.
    always_comb begin
        if (state_q == ST_IDLE) begin
            sel_idx   = win_idx;
            grant_any = win_found & writable;
        end else begin
            sel_idx   = owner_q;
            grant_any = writable & req_pad[owner_q];
        end
        GNT       = '0;
        FIFO_DATA = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            GNT[i] = grant_any && (sel_idx == 3'(i));
            if (GNT[i]) FIFO_DATA = DATA[i*DATA_W +: DATA_W];
        end
        FIFO_WR = |(REQ & GNT);
    end

    // Next-state: burst entry, beat counting, release and abandon.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        beat_d    = beat_q;
        burst_end = ({1'b0, beat_q} + 4'd1) == 4'(MAX_BURST);
        if (EN) begin
            if (state_q == ST_IDLE) begin
                if (grant_any) begin
                    if (last_pad[win_idx] || (MAX_BURST == 1)) begin
                        rr_d = win_idx;
                    end else begin
                        state_d = ST_BURST;
                        owner_d = win_idx;
                        beat_d  = 3'd1;
                    end
                end
            end else begin
                if (!req_pad[owner_q]) begin
                    // Owner withdrew: drop the lock without a transfer.
                    state_d = ST_IDLE;
                    rr_d    = owner_q;
                    beat_d  = '0;
                end else if (grant_any) begin
                    if (last_pad[owner_q] || burst_end) begin
                        state_d = ST_IDLE;
                        rr_d    = owner_q;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            rr_q    <= 3'(N_REQ - 1);
            owner_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            beat_q  <= beat_d;
        end
    end

    assign OWNER = owner_q;
    assign BUSY  = (state_q == ST_BURST);

`ifdef ARB_STATS_EN
    logic [N_REQ-1:0][15:0] xfer_cnt_q;
    logic [15:0]            stall_cnt_q;

    // Saturating transfer and stall counters.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            xfer_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (REQ[i] && GNT[i] && (xfer_cnt_q[i] != 16'hFFFF)) begin
                    xfer_cnt_q[i] <= xfer_cnt_q[i] + 16'd1;
                end
            end
            if (EN && (|REQ) && !writable && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign STAT_XFER  = xfer_cnt_q;
    assign STAT_STALL = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed, table-driven bench for fifo_wr_arbiter
// (N_REQ=4, DATA_W=32, MAX_BURST=4). With ARB_STATS_EN defined it also checks counters.
module tb_fifo_wr_arbiter;

    localparam int unsigned N_REQ     = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MAX_BURST = 4;

    logic                    Clk = 1'b0;
    logic                    Rst = 1'b1;
    logic                    EN = 1'b0;
    logic [N_REQ-1:0]        REQ = '0;
    logic [N_REQ-1:0]        LAST = '0;
    logic [N_REQ*DATA_W-1:0] DATA;
    logic [N_REQ-1:0]        GNT;
    logic                    FIFO_FULL = 1'b0;
    logic                    FIFO_RD = 1'b0;
    logic                    FIFO_WR;
    logic [DATA_W-1:0]       FIFO_DATA;
    logic [2:0]              OWNER;
    logic                    BUSY;
`ifdef ARB_STATS_EN
    logic [N_REQ*16-1:0]     STAT_XFER;
    logic [15:0]             STAT_STALL;
`endif

    int checks   = 0;
    int failures = 0;

    fifo_wr_arbiter #(
        .N_REQ    (N_REQ),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .EN       (EN),
        .REQ      (REQ),
        .LAST     (LAST),
        .DATA     (DATA),
        .GNT      (GNT),
        .FIFO_FULL(FIFO_FULL),
        .FIFO_RD  (FIFO_RD),
        .FIFO_WR  (FIFO_WR),
        .FIFO_DATA(FIFO_DATA),
        .OWNER    (OWNER),
`ifdef ARB_STATS_EN
        .STAT_XFER (STAT_XFER),
        .STAT_STALL(STAT_STALL),
`endif
        .BUSY     (BUSY)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] req;
        logic [3:0] last;
        logic       full;
        logic       rd;
        logic [3:0] gnt;
        logic       wr;
        logic       busy;
        logic [2:0] owner;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] dval(int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0000_1111;
    endfunction

    function automatic logic [31:0] exp_data(logic [3:0] g);
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < 4; i++) if (g[i]) d = dval(i);
        return d;
    endfunction

    task automatic add(input logic rst, input logic en, input logic [3:0] req,
                       input logic [3:0] last, input logic full, input logic rd,
                       input logic [3:0] gnt, input logic wr, input logic busy,
                       input logic [2:0] owner);
        vec_t v;
        v.rst = rst; v.en = en; v.req = req; v.last = last; v.full = full; v.rd = rd;
        v.gnt = gnt; v.wr = wr; v.busy = busy; v.owner = owner;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive at the falling edge; outputs are then sampled 1 time unit later.
    task automatic drive(input logic rst, input logic en, input logic [3:0] req,
                         input logic [3:0] last, input logic full, input logic rd);
        @(negedge Clk);
        Rst = rst; EN = en; REQ = req; LAST = last; FIFO_FULL = full; FIFO_RD = rd;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) DATA[i*DATA_W +: DATA_W] = dval(i);

        //   rst en  req      last     full rd   gnt      wr busy owner
        // Reset, then round-robin single beats 0,1,2,3,0.
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
        add(1, 1, 4'b1111, 4'b1111, 0, 0, 4'b0000, 0, 0, 0);
        add(0, 1, 4'b1111, 4'b1111, 0, 0, 4'b0001, 1, 0, 0);
        add(0, 1, 4'b1111, 4'b1111, 0, 0, 4'b0010, 1, 0, 0);
        add(0, 1, 4'b1111, 4'b1111, 0, 0, 4'b0100, 1, 0, 0);
        add(0, 1, 4'b1111, 4'b1111, 0, 0, 4'b1000, 1, 0, 0);
        add(0, 1, 4'b1111, 4'b1111, 0, 0, 4'b0001, 1, 0, 0);
        // Requester 2 bursts 4 beats, then 0 wins once, then 2 resumes.
        add(0, 1, 4'b0101, 4'b0001, 0, 0, 4'b0100, 1, 0, 0);
        add(0, 1, 4'b0101, 4'b0001, 0, 0, 4'b0100, 1, 1, 2);
        add(0, 1, 4'b0101, 4'b0001, 0, 0, 4'b0100, 1, 1, 2);
        add(0, 1, 4'b0101, 4'b0001, 0, 0, 4'b0100, 1, 1, 2);
        add(0, 1, 4'b0101, 4'b0001, 0, 0, 4'b0001, 1, 0, 2);
        add(0, 1, 4'b0101, 4'b0001, 0, 0, 4'b0100, 1, 0, 2);
        // Beat 2, then FULL for 3 cycles, then exactly 2 more beats.
        add(0, 1, 4'b0100, 4'b0000, 0, 0, 4'b0100, 1, 1, 2);
        add(0, 1, 4'b0100, 4'b0000, 1, 0, 4'b0000, 0, 1, 2);
        add(0, 1, 4'b0100, 4'b0000, 1, 0, 4'b0000, 0, 1, 2);
        add(0, 1, 4'b0100, 4'b0000, 1, 0, 4'b0000, 0, 1, 2);
        add(0, 1, 4'b0100, 4'b0000, 0, 0, 4'b0100, 1, 1, 2);
        add(0, 1, 4'b0100, 4'b0000, 0, 0, 4'b0100, 1, 1, 2);
        add(0, 1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 2);
        // RD blocks the write; it lands on the first RD-free cycle.
        add(0, 1, 4'b0010, 4'b0010, 0, 1, 4'b0000, 0, 0, 2);
        add(0, 1, 4'b0010, 4'b0010, 0, 0, 4'b0010, 1, 0, 2);
        // Owner 0 abandons after beat 1; rr_ptr must become 0 (next winner 1, not 0).
        add(0, 1, 4'b0001, 4'b0000, 0, 0, 4'b0001, 1, 0, 2);
        add(0, 1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 1, 0);
        add(0, 1, 4'b0011, 4'b0011, 0, 0, 4'b0010, 1, 0, 0);
        // EN=0 for 2 cycles at beat 2 freezes everything; burst still ends after beat 4.
        add(0, 1, 4'b0100, 4'b0000, 0, 0, 4'b0100, 1, 0, 0);
        add(0, 1, 4'b0100, 4'b0000, 0, 0, 4'b0100, 1, 1, 2);
        add(0, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 1, 2);
        add(0, 0, 4'b0100, 4'b0000, 0, 0, 4'b0000, 0, 1, 2);
        add(0, 1, 4'b0100, 4'b0000, 0, 0, 4'b0100, 1, 1, 2);
        add(0, 1, 4'b0100, 4'b0000, 0, 0, 4'b0100, 1, 1, 2);
        add(0, 1, 4'b0100, 4'b0000, 0, 0, 4'b0100, 1, 0, 2);
        // Reset mid-burst: back to IDLE with rr_ptr=3, so {2,3} picks 2.
        add(1, 1, 4'b0100, 4'b0000, 0, 0, 4'b0000, 0, 1, 2);
        add(0, 1, 4'b1100, 4'b1100, 0, 0, 4'b0100, 1, 0, 0);

        foreach (vecs[n]) begin
            drive(vecs[n].rst, vecs[n].en, vecs[n].req, vecs[n].last, vecs[n].full, vecs[n].rd);
            check($sformatf("v%0d GNT", n), 32'(GNT), 32'(vecs[n].gnt));
            check($sformatf("v%0d FIFO_WR", n), 32'(FIFO_WR), 32'(vecs[n].wr));
            check($sformatf("v%0d FIFO_DATA", n), FIFO_DATA, exp_data(vecs[n].gnt));
            check($sformatf("v%0d BUSY", n), 32'(BUSY), 32'(vecs[n].busy));
            check($sformatf("v%0d OWNER", n), 32'(OWNER), 32'(vecs[n].owner));
        end

        // Requester 3 held permanently: served every cycle, releasing every 4 beats.
        drive(1, 0, 4'b0000, 4'b0000, 0, 0);
        for (int k = 0; k < 9; k++) begin
            drive(0, 1, 4'b1000, 4'b0000, 0, 0);
            check($sformatf("hold%0d GNT", k), 32'(GNT), 32'h8);
            check($sformatf("hold%0d BUSY", k), 32'(BUSY), 32'((k % 4) != 0));
        end
        // At a release boundary requester 0 wins the next arbitration.
        drive(0, 1, 4'b1001, 4'b0000, 0, 0);
        check("hold_rel BUSY", 32'(BUSY), 32'h1);
        drive(0, 1, 4'b1001, 4'b0000, 0, 0);
        check("hold_rel2 GNT", 32'(GNT), 32'h8);
        drive(0, 1, 4'b1001, 4'b0000, 0, 0);
        check("hold_rel3 GNT", 32'(GNT), 32'h8);
        drive(0, 1, 4'b1001, 4'b0000, 0, 0);
        check("hold_next GNT", 32'(GNT), 32'h1);
        check("hold_next BUSY", 32'(BUSY), 32'h0);

`ifdef ARB_STATS_EN
        // 10 single-beat transfers from requester 3 and 5 FULL stalls.
        drive(1, 1, 4'b0000, 4'b0000, 0, 0);
        drive(1, 1, 4'b0000, 4'b0000, 0, 0);
        for (int k = 0; k < 10; k++) drive(0, 1, 4'b1000, 4'b1000, 0, 0);
        for (int k = 0; k < 5; k++) drive(0, 1, 4'b1000, 4'b1000, 1, 0);
        drive(0, 1, 4'b0000, 4'b0000, 0, 0);
        check("stat xfer3", 32'(STAT_XFER[3*16 +: 16]), 32'd10);
        check("stat xfer0", 32'(STAT_XFER[0 +: 16]), 32'd0);
        check("stat stall", 32'(STAT_STALL), 32'd5);
        drive(1, 0, 4'b0000, 4'b0000, 0, 0);
        drive(0, 0, 4'b0000, 4'b0000, 0, 0);
        check("stat xfer3 clr", 32'(STAT_XFER[3*16 +: 16]), 32'd0);
        check("stat stall clr", 32'(STAT_STALL), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
